// File: rtl/bulk_in_packetiser_pkg.sv
// Shared USB definitions for the bulk IN packetiser: PID codes, the
// packetiser state encoding and default max-packet sizes.
package bulk_in_packetiser_pkg;

    // USB packet identifiers (4-bit PID field, low nibble on the wire first).
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // Default bulk max-packet sizes in bytes.
    localparam int MAX_PKT_HS_DEF = 512;
    localparam int MAX_PKT_FS_DEF = 64;

    // Packetiser control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_ZLP     = 2'd2,
        ST_WAIT_HS = 2'd3
    } pkt_state_t;

    // Selects the data PID for the current toggle value.
    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/bulk_in_packetiser.sv
// Bulk IN endpoint packetiser: answers IN tokens with data, NAK or STALL,
// cuts the FIFO byte stream into max-packet-size packets, inserts a ZLP
// after a frame that ends on a packet boundary and tracks the data toggle.
module bulk_in_packetiser
    import bulk_in_packetiser_pkg::*;
#(
    parameter int MAX_PKT_HS = MAX_PKT_HS_DEF,
    parameter int MAX_PKT_FS = MAX_PKT_FS_DEF,
    parameter int CWIDTH     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hs_mode_i,
    input  logic       halt_i,
    input  logic       clear_toggle_i,
    input  logic       token_i,
    input  logic       ack_i,
    input  logic       timeout_i,
    input  logic       has_data_i,
    output logic       xfer_o,
    input  logic       s_tvalid_i,
    output logic       s_tready_o,
    input  logic       s_tlast_i,
    input  logic [7:0] s_tdata_i,
    output logic       m_tvalid_o,
    input  logic       m_tready_i,
    output logic       m_tlast_o,
    output logic [7:0] m_tdata_o,
    output logic       m_zlp_o,
    output logic [3:0] m_pid_o,
    output logic       nak_o,
    output logic       stall_o,
    output logic       err_o
);

    pkt_state_t        state_q, state_d;
    logic              toggle_q;
    logic              zlp_pending_q;
    logic              max_hs_q;
    logic [CWIDTH-1:0] count_q;
    logic [CWIDTH-1:0] count_last;
    logic              count_at_max;
    logic              beat_last;
    logic              beat_hs;
    logic              accept_data;
    logic              accept_zlp;
    logic              ack_flip;
    logic              nak_d, stall_d, err_d;
    logic              nak_q, stall_q, err_q;

    // Index of the final byte of a full packet for the latched bus speed.
    assign count_last   = max_hs_q ? CWIDTH'(MAX_PKT_HS - 1) : CWIDTH'(MAX_PKT_FS - 1);
    assign count_at_max = (count_q == count_last);

    // The FIFO transfer request is held for exactly the data phase.
    assign xfer_o  = (state_q == ST_DATA);
    assign nak_o   = nak_q;
    assign stall_o = stall_q;
    assign err_o   = err_q;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, stream steering and handshake pulse requests.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case can leave a latch behind.
        state_d     = state_q;
        m_tvalid_o  = 1'b0;
        m_tlast_o   = 1'b0;
        m_tdata_o   = 8'h00;
        m_zlp_o     = 1'b0;
        s_tready_o  = 1'b0;
        beat_last   = 1'b0;
        beat_hs     = 1'b0;
        accept_data = 1'b0;
        accept_zlp  = 1'b0;
        ack_flip    = 1'b0;
        nak_d       = 1'b0;
        stall_d     = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (token_i) begin
                    if (halt_i) begin
                        stall_d = 1'b1;
                    end else if (zlp_pending_q) begin
                        accept_zlp = 1'b1;
                        state_d    = ST_ZLP;
                    end else if (has_data_i) begin
                        accept_data = 1'b1;
                        state_d     = ST_DATA;
                    end else begin
                        nak_d = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                // Straight combinational pass-through; a source bubble
                // simply shows up as m_tvalid_o low.
                beat_last  = s_tlast_i | count_at_max;
                m_tvalid_o = s_tvalid_i;
                s_tready_o = m_tready_i;
                m_tdata_o  = s_tdata_i;
                m_tlast_o  = beat_last;
                beat_hs    = s_tvalid_i & m_tready_i;
                if (beat_hs && beat_last) begin
                    state_d = ST_WAIT_HS;
                end
            end

            ST_ZLP: begin
                m_tvalid_o = 1'b1;
                m_tlast_o  = 1'b1;
                m_zlp_o    = 1'b1;
                if (m_tready_i) begin
                    state_d = ST_WAIT_HS;
                end
            end

            ST_WAIT_HS: begin
                // ACK wins over a coincident timeout; nothing is replayed.
                if (ack_i) begin
                    ack_flip = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timeout_i) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Packet context: byte counter, speed, PID, toggle, ZLP flag and pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            toggle_q      <= 1'b0;
            zlp_pending_q <= 1'b0;
            max_hs_q      <= 1'b0;
            count_q       <= '0;
            m_pid_o       <= PID_DATA0;
            nak_q         <= 1'b0;
            stall_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            nak_q   <= nak_d;
            stall_q <= stall_d;
            err_q   <= err_d;

            if (accept_data) begin
                max_hs_q <= hs_mode_i;
                count_q  <= '0;
            end else if (beat_hs) begin
                count_q <= count_q + 1'b1;
            end

            if (accept_data || accept_zlp) begin
                m_pid_o <= data_pid(toggle_q);
            end

            // A frame ending on the last byte of a full packet owes a ZLP.
            if (beat_hs && beat_last) begin
                zlp_pending_q <= s_tlast_i & count_at_max;
            end else if (state_q == ST_ZLP && m_tready_i) begin
                zlp_pending_q <= 1'b0;
            end

            // Host reconfiguration beats a same-cycle ACK.
            if (clear_toggle_i) begin
                toggle_q <= 1'b0;
            end else if (ack_flip) begin
                toggle_q <= ~toggle_q;
            end
        end
    end

endmodule

// File: tb/tb_bulk_in_packetiser.sv
// Directed self-checking bench for bulk_in_packetiser. Inputs change 1 ns
// after the rising edge; outputs are sampled before the following edge.
module tb_bulk_in_packetiser;

    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;

    logic       clock = 1'b0;
    logic       reset;
    logic       hs_mode_i, halt_i, clear_toggle_i, token_i, ack_i, timeout_i;
    logic       has_data_i, xfer_o;
    logic       s_tvalid_i, s_tready_o, s_tlast_i;
    logic [7:0] s_tdata_i;
    logic       m_tvalid_o, m_tready_i, m_tlast_o, m_zlp_o;
    logic [7:0] m_tdata_o;
    logic [3:0] m_pid_o;
    logic       nak_o, stall_o, err_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame [0:127];
    int         frame_len;
    int         pos;

    always #5 clock = ~clock;

    bulk_in_packetiser dut (
        .clock          (clock),
        .reset          (reset),
        .hs_mode_i      (hs_mode_i),
        .halt_i         (halt_i),
        .clear_toggle_i (clear_toggle_i),
        .token_i        (token_i),
        .ack_i          (ack_i),
        .timeout_i      (timeout_i),
        .has_data_i     (has_data_i),
        .xfer_o         (xfer_o),
        .s_tvalid_i     (s_tvalid_i),
        .s_tready_o     (s_tready_o),
        .s_tlast_i      (s_tlast_i),
        .s_tdata_i      (s_tdata_i),
        .m_tvalid_o     (m_tvalid_o),
        .m_tready_i     (m_tready_i),
        .m_tlast_o      (m_tlast_o),
        .m_tdata_o      (m_tdata_o),
        .m_zlp_o        (m_zlp_o),
        .m_pid_o        (m_pid_o),
        .nak_o          (nak_o),
        .stall_o        (stall_o),
        .err_o          (err_o)
    );

    // One-cycle pulse helpers; each starts and ends 1 ns after a rising edge.
    task automatic pulse_token();
        token_i = 1'b1;
        @(posedge clock); #1;
        token_i = 1'b0;
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        @(posedge clock); #1;
        ack_i = 1'b0;
    endtask

    task automatic load_frame(input int len, input int base);
        frame_len = len;
        pos       = 0;
        for (int i = 0; i < len; i++) frame[i] = 8'(base + i);
    endtask

    // Feeds the frame from pos with a ready sink and checks one packet.
    task automatic stream_packet(input int exp_len, input logic [3:0] exp_pid, input string name);
        int beat = 0;
        bit done = 0;
        bit hs, last;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = frame[pos];
            s_tlast_i  = (pos == frame_len - 1);
            m_tready_i = 1'b1;
            #1;
            checks++;
            if (m_tvalid_o !== 1'b1 || m_tdata_o !== frame[pos] || m_pid_o !== exp_pid || xfer_o !== 1'b1) begin
                errors++;
                $display("FAIL %s beat %0d: valid=%b data=%h pid=%b xfer=%b, expected valid=1 data=%h pid=%b xfer=1",
                         name, beat, m_tvalid_o, m_tdata_o, m_pid_o, xfer_o, frame[pos], exp_pid);
            end
            checks++;
            if (m_tlast_o !== (beat == exp_len - 1)) begin
                errors++;
                $display("FAIL %s tlast beat %0d: got %b, expected %b", name, beat, m_tlast_o, (beat == exp_len - 1));
            end
            hs   = m_tvalid_o && m_tready_i;
            last = m_tlast_o;
            @(posedge clock); #1;
            if (hs) begin
                pos++;
                beat++;
                if (last) done = 1;
            end
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tdata_i  = 8'h00;
        m_tready_i = 1'b0;
        checks++;
        if (!done || beat != exp_len) begin
            errors++;
            $display("FAIL %s length: got %0d beats (ended=%0d), expected %0d", name, beat, done, exp_len);
        end
        checks++;
        if (xfer_o !== 1'b0) begin
            errors++;
            $display("FAIL %s xfer after packet: got %b, expected 0", name, xfer_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({xfer_o, s_tready_o, m_tvalid_o, m_tlast_o, m_zlp_o, nak_o, stall_o, err_o} !== 8'h00
            || m_tdata_o !== 8'h00 || m_pid_o !== DATA0) begin
            errors++;
            $display("FAIL reset outputs: ctl=%b data=%h pid=%b, expected ctl=00000000 data=00 pid=%b",
                     {xfer_o, s_tready_o, m_tvalid_o, m_tlast_o, m_zlp_o, nak_o, stall_o, err_o},
                     m_tdata_o, m_pid_o, DATA0);
        end
        reset = 1'b0;
    endtask

    task automatic test_short_frame();
        frame_len = 3;
        pos       = 0;
        frame[0]  = 8'hAA;
        frame[1]  = 8'hBB;
        frame[2]  = 8'hCC;
        has_data_i = 1'b1;
        checks++;
        if (xfer_o !== 1'b0) begin
            errors++;
            $display("FAIL short xfer before token: got %b, expected 0", xfer_o);
        end
        pulse_token();
        stream_packet(3, DATA0, "short");
        has_data_i = 1'b0;
        pulse_ack();
    endtask

    task automatic test_fs_split();
        clear_toggle_i = 1'b1;
        @(posedge clock); #1;
        clear_toggle_i = 1'b0;
        hs_mode_i = 1'b0;
        load_frame(100, 1);
        has_data_i = 1'b1;
        pulse_token();
        stream_packet(64, DATA0, "fs_pkt1");
        pulse_ack();
        pulse_token();
        stream_packet(36, DATA1, "fs_pkt2");
        has_data_i = 1'b0;
        pulse_ack();
    endtask

    task automatic test_zlp();
        hs_mode_i = 1'b0;
        load_frame(64, 8'h40);
        has_data_i = 1'b1;
        pulse_token();
        stream_packet(64, DATA0, "zlp_frame");
        has_data_i = 1'b0;
        pulse_ack();
        pulse_token();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_tvalid_o !== 1'b1 || m_tlast_o !== 1'b1 || m_zlp_o !== 1'b1 || s_tready_o !== 1'b0
                || xfer_o !== 1'b0 || m_pid_o !== DATA1) begin
                errors++;
                $display("FAIL zlp beat cycle %0d: valid=%b last=%b zlp=%b sready=%b xfer=%b pid=%b, expected 1 1 1 0 0 %b",
                         i, m_tvalid_o, m_tlast_o, m_zlp_o, s_tready_o, xfer_o, m_pid_o, DATA1);
            end
            if (i == 0) begin
                @(posedge clock); #1;
            end
        end
        m_tready_i = 1'b1;
        @(posedge clock); #1;
        m_tready_i = 1'b0;
        checks++;
        if (m_tvalid_o !== 1'b0 || m_zlp_o !== 1'b0) begin
            errors++;
            $display("FAIL zlp after accept: valid=%b zlp=%b, expected 0 0", m_tvalid_o, m_zlp_o);
        end
        pulse_ack();
        pulse_token();
        checks++;
        if (nak_o !== 1'b1 || m_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL zlp then empty: nak=%b valid=%b, expected nak=1 valid=0", nak_o, m_tvalid_o);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_nak_stall();
        has_data_i = 1'b0;
        pulse_token();
        checks++;
        if (nak_o !== 1'b1 || xfer_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL nak pulse: nak=%b xfer=%b stall=%b, expected 1 0 0", nak_o, xfer_o, stall_o);
        end
        @(posedge clock); #1;
        checks++;
        if (nak_o !== 1'b0) begin
            errors++;
            $display("FAIL nak width: got %b, expected 0", nak_o);
        end
        halt_i     = 1'b1;
        has_data_i = 1'b1;
        pulse_token();
        checks++;
        if (stall_o !== 1'b1 || nak_o !== 1'b0 || xfer_o !== 1'b0 || s_tready_o !== 1'b0 || m_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall pulse: stall=%b nak=%b xfer=%b sready=%b valid=%b, expected 1 0 0 0 0",
                     stall_o, nak_o, xfer_o, s_tready_o, m_tvalid_o);
        end
        @(posedge clock); #1;
        checks++;
        if (stall_o !== 1'b0 || xfer_o !== 1'b0) begin
            errors++;
            $display("FAIL stall after: stall=%b xfer=%b, expected 0 0", stall_o, xfer_o);
        end
        halt_i     = 1'b0;
        has_data_i = 1'b0;
    endtask

    task automatic test_timeout();
        load_frame(2, 8'h70);
        has_data_i = 1'b1;
        pulse_token();
        stream_packet(2, DATA0, "to_pkt1");
        has_data_i = 1'b0;
        timeout_i = 1'b1;
        @(posedge clock); #1;
        timeout_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout err: got %b, expected 1", err_o);
        end
        @(posedge clock); #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout err width: got %b, expected 0", err_o);
        end
        pos        = 0;
        has_data_i = 1'b1;
        pulse_token();
        stream_packet(2, DATA0, "to_pkt2_same_pid");
        has_data_i = 1'b0;
        ack_i     = 1'b1;
        timeout_i = 1'b1;
        @(posedge clock); #1;
        ack_i     = 1'b0;
        timeout_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || m_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL ack+timeout: err=%b valid=%b, expected 0 0", err_o, m_tvalid_o);
        end
    endtask

    task automatic test_clear_and_reset();
        load_frame(1, 8'h90);
        has_data_i = 1'b1;
        pulse_token();
        stream_packet(1, DATA1, "ct_pkt");
        has_data_i     = 1'b0;
        ack_i          = 1'b1;
        clear_toggle_i = 1'b1;
        @(posedge clock); #1;
        ack_i          = 1'b0;
        clear_toggle_i = 1'b0;
        hs_mode_i  = 1'b1;
        load_frame(20, 8'hA0);
        has_data_i = 1'b1;
        pulse_token();
        checks++;
        if (m_pid_o !== DATA0 || xfer_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_toggle pid: pid=%b xfer=%b, expected pid=%b xfer=1", m_pid_o, xfer_o, DATA0);
        end
        for (int i = 0; i < 10; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = frame[pos];
            s_tlast_i  = 1'b0;
            m_tready_i = 1'b1;
            #1;
            checks++;
            if (m_tdata_o !== frame[pos] || m_tlast_o !== 1'b0) begin
                errors++;
                $display("FAIL hs beat %0d: data=%h last=%b, expected data=%h last=0", i, m_tdata_o, m_tlast_o, frame[pos]);
            end
            @(posedge clock); #1;
            pos++;
        end
        s_tdata_i = frame[pos];
        reset     = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({xfer_o, s_tready_o, m_tvalid_o, m_tlast_o, m_zlp_o, nak_o, stall_o, err_o} !== 8'h00
            || m_tdata_o !== 8'h00 || m_pid_o !== DATA0) begin
            errors++;
            $display("FAIL reset mid-packet: ctl=%b data=%h pid=%b, expected ctl=00000000 data=00 pid=%b",
                     {xfer_o, s_tready_o, m_tvalid_o, m_tlast_o, m_zlp_o, nak_o, stall_o, err_o},
                     m_tdata_o, m_pid_o, DATA0);
        end
        reset      = 1'b0;
        s_tvalid_i = 1'b0;
        s_tdata_i  = 8'h00;
        m_tready_i = 1'b0;
        has_data_i = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        hs_mode_i      = 1'b0;
        halt_i         = 1'b0;
        clear_toggle_i = 1'b0;
        token_i        = 1'b0;
        ack_i          = 1'b0;
        timeout_i      = 1'b0;
        has_data_i     = 1'b0;
        s_tvalid_i     = 1'b0;
        s_tlast_i      = 1'b0;
        s_tdata_i      = 8'h00;
        m_tready_i     = 1'b0;
        frame_len      = 0;
        pos            = 0;

        test_reset();
        test_short_frame();
        test_fs_split();
        test_zlp();
        test_nak_stall();
        test_timeout();
        test_clear_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
